// File: rtl/sha256_digest_ser.sv
// sha256_digest_ser
// Captures a finished 256-bit SHA-256 digest and streams it out as eight
// 32-bit words over a valid/ready handshake, H0 first. A digest strobe that
// arrives while a stream is still in flight is discarded and flagged.
//
// Ports:
//   clk            clock
//   rst            synchronous reset, active-low
//   digest_valid_i one-cycle strobe: digest_i carries a new final hash
//   digest_i       final hash {H0..H7}, H0 in the top word
//   word_ready_i   downstream accepts word_o this cycle
//   word_o         current output word (zero outside SEND)
//   word_valid_o   word_o valid
//   word_last_o    high with the final word (idx 7)
//   word_idx_o     index of word_o
//   busy_o         high while streaming
//   done_o         one-cycle pulse after the last word transferred
//   drop_o         sticky overflow flag
//   clr_drop_i     clears drop_o (a same-cycle new overflow wins)
module sha256_digest_ser #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        digest_valid_i,
    input  logic [WORD_W*NUM_WORDS-1:0] digest_i,
    input  logic                        word_ready_i,
    output logic [WORD_W-1:0]           word_o,
    output logic                        word_valid_o,
    output logic                        word_last_o,
    output logic [2:0]                  word_idx_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        drop_o,
    input  logic                        clr_drop_i
);

    localparam int DIGEST_W = WORD_W * NUM_WORDS;
    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t              state_reg,  state_next;
    logic [DIGEST_W-1:0] buffer_reg, buffer_next;
    logic [DIGEST_W-1:0] buffer_shifted;
    logic [2:0]          idx_reg,    idx_next;
    logic                drop_reg,   drop_next;

    // Shift the buffer up by one word so the next word lands in the top slot.
    assign buffer_shifted[WORD_W-1:0] = '0;
    generate
        for (genvar gi = 1; gi < NUM_WORDS; gi++) begin : g_shift
            assign buffer_shifted[gi*WORD_W +: WORD_W] = buffer_reg[(gi-1)*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            buffer_reg <= '0;
            idx_reg    <= '0;
            drop_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buffer_reg <= buffer_next;
            idx_reg    <= idx_next;
            drop_reg   <= drop_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        buffer_next = buffer_reg;
        idx_next    = idx_reg;
        drop_next   = drop_reg;

        case (state_reg)
            IDLE: begin
                if (digest_valid_i) begin
                    buffer_next = digest_i;
                    idx_next    = '0;
                    state_next  = SEND;
                end
            end
            SEND: begin
                if (word_ready_i) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        buffer_next = buffer_shifted;
                        idx_next    = idx_reg + 3'd1;
                    end
                end
            end
            DONE: begin
                // Accepting here keeps back-to-back digests at 9 cycles each.
                if (digest_valid_i) begin
                    buffer_next = digest_i;
                    idx_next    = '0;
                    state_next  = SEND;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // New overflow takes priority over a clear in the same cycle.
        if (state_reg == SEND && digest_valid_i) begin
            drop_next = 1'b1;
        end else if (clr_drop_i) begin
            drop_next = 1'b0;
        end
    end

    assign word_valid_o = (state_reg == SEND);
    assign busy_o       = (state_reg == SEND);
    assign done_o       = (state_reg == DONE);
    assign word_o       = (state_reg == SEND) ? buffer_reg[DIGEST_W-1 -: WORD_W] : '0;
    assign word_idx_o   = idx_reg;
    assign word_last_o  = (state_reg == SEND) && (idx_reg == LAST_IDX);
    assign drop_o       = drop_reg;

endmodule

// File: doc/sha256_digest_ser.md
Name: sha256_digest_ser

Overview:
Downstream consumer of the 256-bit SHA-256 result register. Captures a finished digest and emits it as eight 32-bit words over a valid/ready stream, most-significant word (H0+A) first. Flags any digest that arrives while a previous one is still being sent. Feeds the host/output interface of the SHA core.

Parameters:
WORD_W, 32, width of each output word
NUM_WORDS, 8, words per digest; digest width = WORD_W*NUM_WORDS (256)

Ports:
clk  in  1  clock
rst  in  1  reset, active-low, synchronous (sampled on posedge clk only)
digest_valid_i  in  1  one-cycle strobe; digest_i holds a new final hash this cycle
digest_i  in  256  final hash {H0..H7}, H0 in [255:224]
word_ready_i  in  1  downstream accepts word_o this cycle
word_o  out  32  current output word
word_valid_o  out  1  word_o valid
word_last_o  out  1  high with the 8th word (idx 7)
word_idx_o  out  3  index of word_o, 0..7
busy_o  out  1  high in SEND
done_o  out  1  one-cycle pulse after last word transferred
drop_o  out  1  sticky: digest_valid_i arrived during SEND
clr_drop_i  in  1  clears drop_o

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; word_o=0, word_valid_o=0, word_last_o=0, word_idx_o=0, busy_o=0, done_o=0, drop_o=0; shift buffer=0. Reset mid-transfer aborts the digest; nothing further is emitted.
- States: IDLE, SEND, DONE.
- IDLE: digest_valid_i=1 -> load buffer with digest_i, idx=0, go SEND. Otherwise stay.
- SEND:
  - word_valid_o=1, busy_o=1, word_o=buffer[255:224], word_idx_o=idx, word_last_o=(idx==7).
  - Transfer = word_valid_o & word_ready_i.
  - On transfer with idx<7: buffer shifts left 32, idx+1.
  - On transfer with idx==7: go DONE.
  - If word_ready_i=0: word_o, word_idx_o and word_last_o stay stable. No word is skipped or repeated.
- DONE: done_o=1 for exactly this cycle; word_valid_o=0, busy_o=0.
  - digest_valid_i=1 -> capture and go SEND (back-to-back allowed).
  - Else go IDLE.
- Latency:
  - Strobe at cycle N -> first word valid at N+1.
  - With ready held high: words at N+1..N+8, done_o at N+9.
  - Sustained throughput: one digest per 9 cycles.
- Overflow: digest_valid_i=1 in SEND -> digest ignored, current stream unaffected, drop_o<=1.
  - drop_o clears only on clr_drop_i=1.
  - Same-cycle new drop and clr_drop_i -> drop_o=1 (set wins).
- digest_i is sampled only on the accepting strobe; later changes on digest_i do not affect the words in flight.
- No arithmetic; pure capture and shift. Word order is H0..H7.

Test Plan:
- Basic: after reset, strobe digest_i = SHA256("abc") = ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad with ready=1 -> words ba7816bf..f20015ad at N+1..N+8; idx 0..7; last only on f20015ad; done_o at N+9.
- Backpressure: same digest, ready low on cycles N+2..N+4 and on odd cycles thereafter -> word_o holds 8f01cfea while stalled; exactly 8 transfers in order; done_o once.
- Overflow: strobe digest 0x00..01 (256-bit), then strobe digest 0xFF..FF at N+3 -> drop_o=1 from N+4; output still 00000000 x7, 00000001. clr_drop_i at N+12 -> drop_o=0. Repeat with clr_drop_i in the same cycle as a new drop -> drop_o=1.
- Back-to-back: strobe digest A; strobe digest B exactly on A's done_o cycle -> B's first word valid the next cycle; A and B both complete, drop_o stays 0.
- Reset mid-operation: rst=0 for one cycle during idx=3 -> next cycle word_valid_o=0, idx=0, done_o never pulses. A fresh strobe then streams from word 0.
- Idle stability: no strobe for 20 cycles, ready toggling -> word_valid_o=0, done_o=0, busy_o=0 throughout.
